// File: rtl/quad_encoder_frontend_if.sv
`default_nettype none
// ============================================================================
// Module  : quad_encoder_frontend_if
// Purpose : Bundles the encoder pins, the enable and the level/strobe
//           outputs of one quadrature-encoder channel.
// Ports   : enc_a, enc_b - raw encoder phases (asynchronous to clk)
//           ena          - 1 = level may change, 0 = level frozen
//           value        - WIDTH-bit current level
//           changed      - one-cycle strobe when value is written
//           dir          - direction of last valid step (1 = up)
//           illegal      - one-cycle strobe on a double-bit transition
// Modports: master drives the pins/enable, slave (the frontend) drives
//           the level and strobes.
// Revision: 1.0 - initial release
// ============================================================================
interface quad_encoder_frontend_if #(
  parameter int WIDTH = 8
);
  logic             enc_a;
  logic             enc_b;
  logic             ena;
  logic [WIDTH-1:0] value;
  logic             changed;
  logic             dir;
  logic             illegal;

  modport master (
    output enc_a, enc_b, ena,
    input  value, changed, dir, illegal
  );

  modport slave (
    input  enc_a, enc_b, ena,
    output value, changed, dir, illegal
  );
endinterface
`default_nettype wire

// File: rtl/quad_encoder_frontend.sv
`default_nettype none
// ============================================================================
// Module  : quad_encoder_frontend
// Purpose : Per-channel rotary encoder input stage. Two-flop synchronises and
//           debounces the A/B phases, decodes quadrature steps and keeps a
//           WIDTH-bit level with change strobe, direction and an illegal
//           (double-bit) transition strobe.
// Ports   : clk   - system clock
//           rst_n - asynchronous active-low reset
//           bus   - quad_encoder_frontend_if.slave (enc_a, enc_b, ena in;
//                   value, changed, dir, illegal out)
// Options : ENC_SATURATE_EN - when defined the level clamps at 0 and
//           2^WIDTH-1; when undefined it wraps modulo 2^WIDTH.
// Revision: 1.0 - initial release
// ============================================================================
module quad_encoder_frontend #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP            = 1,
  parameter int RESET_VALUE     = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  quad_encoder_frontend_if.slave bus
);

  // DEBOUNCE_CYCLES is at most 65535, so a 16-bit counter always suffices.
  localparam int               c_cnt_w       = 16;
  localparam int               c_arith_w     = WIDTH + 1;
  localparam logic [c_cnt_w-1:0]   c_cnt_last    = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_arith_w-1:0] c_step        = c_arith_w'(STEP);
  localparam logic [WIDTH-1:0]     c_reset_value = WIDTH'(RESET_VALUE);

  // Bit 1 = phase A, bit 0 = phase B throughout.
  logic [1:0] w_raw;
  logic [1:0] w_stable;

  assign w_raw = {bus.enc_a, bus.enc_b};

  // --------------------------------------------------------------------------
  // Synchroniser + debounce, one independent copy per phase.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_phase
    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1  <= 1'b0;
        r_sync2  <= 1'b0;
        r_stable <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_sync1 <= w_raw[g];
        r_sync2 <= r_sync1;
        if (r_sync2 == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
          // Mismatch has now persisted DEBOUNCE_CYCLES cycles: accept it.
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_stable[g] = r_stable;
  end

  // --------------------------------------------------------------------------
  // Quadrature decode: up order is 00 -> 10 -> 11 -> 01 -> 00.
  // --------------------------------------------------------------------------
  logic [1:0]           r_prev;
  logic                 w_up;
  logic                 w_down;
  logic                 w_illegal;
  logic [c_arith_w-1:0] w_sum;
  logic [c_arith_w-1:0] w_diff;
  logic [WIDTH-1:0]     w_next;

  always_comb begin
    w_up      = 1'b0;
    w_down    = 1'b0;
    w_illegal = ((r_prev ^ w_stable) == 2'b11);
    case ({r_prev, w_stable})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_up   = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_down = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Level arithmetic one bit wider than the level so the top bit flags
  // carry (up) or borrow (down).
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_value;
  logic             r_changed;
  logic             r_dir;
  logic             r_illegal;

  always_comb begin
    w_sum  = {1'b0, r_value} + c_step;
    w_diff = {1'b0, r_value} - c_step;
`ifdef ENC_SATURATE_EN
    if (w_up) begin
      w_next = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    end else begin
      w_next = w_diff[WIDTH] ? {WIDTH{1'b0}} : w_diff[WIDTH-1:0];
    end
`else
    w_next = w_up ? w_sum[WIDTH-1:0] : w_diff[WIDTH-1:0];
`endif
  end

  // Previous state is tracked even while ena = 0, so steps taken while
  // frozen are dropped rather than replayed later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev    <= 2'b00;
      r_value   <= c_reset_value;
      r_changed <= 1'b0;
      r_dir     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_prev    <= w_stable;
      r_illegal <= w_illegal;
      r_changed <= 1'b0;
      if (bus.ena && (w_up || w_down)) begin
        r_value   <= w_next;
        r_changed <= 1'b1;
        r_dir     <= w_up;
      end
    end
  end

  assign bus.value   = r_value;
  assign bus.changed = r_changed;
  assign bus.dir     = r_dir;
  assign bus.illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_frontend.sv
`default_nettype none
// ============================================================================
// Module  : tb_quad_encoder_frontend
// Purpose : Self-checking bench for quad_encoder_frontend (WIDTH=8,
//           DEBOUNCE_CYCLES=4, STEP=1, RESET_VALUE=0x10). Expected values
//           come from a position-on-a-circle model of the encoder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_quad_encoder_frontend;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int STP  = 1;
  localparam int RV   = 16;
  localparam int VMAX = (1 << W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  quad_encoder_frontend_if #(.WIDTH(W)) bus ();

  quad_encoder_frontend #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .STEP           (STP),
    .RESET_VALUE    (RV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: detent position index around the circle, level and direction.
  // idx_of maps {A,B} to its place in the up order 00,10,11,01.
  int         idx_of [4] = '{0, 3, 1, 2};
  logic [1:0] pos_of [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] m_pos;
  int         m_value;
  logic       m_dir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a level (at a falling edge) and watch `hold` rising edges.
  task automatic run_level(input logic [1:0] lvl, input logic en, input int hold,
                           output int ch_cnt, output int ch_edge,
                           output int il_cnt, output int il_edge);
    @(negedge clk);
    bus.enc_a = lvl[1];
    bus.enc_b = lvl[0];
    bus.ena   = en;
    ch_cnt = 0; ch_edge = -1; il_cnt = 0; il_edge = -1;
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk);
      #1;
      if (bus.changed === 1'b1) begin
        ch_cnt++;
        if (ch_edge < 0) ch_edge = k;
      end
      if (bus.illegal === 1'b1) begin
        il_cnt++;
        if (il_edge < 0) il_edge = k;
      end
    end
  endtask

  task automatic step(input logic [1:0] lvl, input logic en, input int hold);
    int d, ch_cnt, ch_edge, il_cnt, il_edge;
    logic exp_ch, exp_il;
    d      = (idx_of[lvl] - idx_of[m_pos] + 4) % 4;
    exp_ch = en && (d == 1 || d == 3);
    exp_il = (d == 2);
    if (exp_ch) begin
      if (d == 1) begin
`ifdef ENC_SATURATE_EN
        m_value = (m_value + STP > VMAX) ? VMAX : m_value + STP;
`else
        m_value = (m_value + STP) % (VMAX + 1);
`endif
        m_dir = 1'b1;
      end else begin
`ifdef ENC_SATURATE_EN
        m_value = (m_value - STP < 0) ? 0 : m_value - STP;
`else
        m_value = (m_value - STP + VMAX + 1) % (VMAX + 1);
`endif
        m_dir = 1'b0;
      end
    end
    m_pos = lvl;
    run_level(lvl, en, hold, ch_cnt, ch_edge, il_cnt, il_edge);
    check("changed_count", ch_cnt, exp_ch);
    if (exp_ch) check("changed_latency", ch_edge, D + 3);
    check("illegal_count", il_cnt, exp_il);
    if (exp_il) check("illegal_latency", il_edge, D + 3);
    check("value", bus.value, m_value);
    check("dir", bus.dir, m_dir);
  endtask

  task automatic step_dir(input logic up, input logic en, input int hold);
    step(pos_of[(idx_of[m_pos] + (up ? 1 : 3)) % 4], en, hold);
  endtask

  // Short excursion away from the current level, then back; must be ignored.
  task automatic glitch(input logic [1:0] lvl, input int len);
    int cc, ic;
    cc = 0; ic = 0;
    @(negedge clk);
    bus.enc_a = lvl[1];
    bus.enc_b = lvl[0];
    repeat (len) begin
      @(posedge clk); #1;
      cc += int'(bus.changed === 1'b1);
      ic += int'(bus.illegal === 1'b1);
    end
    @(negedge clk);
    bus.enc_a = m_pos[1];
    bus.enc_b = m_pos[0];
    repeat (D + 4) begin
      @(posedge clk); #1;
      cc += int'(bus.changed === 1'b1);
      ic += int'(bus.illegal === 1'b1);
    end
    check("glitch_changed", cc, 0);
    check("glitch_illegal", ic, 0);
    check("glitch_value", bus.value, m_value);
  endtask

  // Present a raw level, let the debounce counter start, reset
  // asynchronously between edges, then release and expect a full-latency
  // response to the level that is still held.
  task automatic do_reset(input logic [1:0] lvl);
    @(negedge clk);
    bus.enc_a = lvl[1];
    bus.enc_b = lvl[0];
    bus.ena   = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_value", bus.value, RV);
    check("rst_changed", bus.changed, 0);
    check("rst_dir", bus.dir, 0);
    check("rst_illegal", bus.illegal, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    m_pos   = 2'b00;
    m_value = RV;
    m_dir   = 1'b0;
    step(lvl, 1'b1, D + 8);
  endtask

  logic [1:0] r_mask;
  int         kind;

  initial begin
    bus.enc_a = 1'b0;
    bus.enc_b = 1'b0;
    bus.ena   = 1'b1;
    m_pos     = 2'b00;
    m_value   = RV;
    m_dir     = 1'b0;

    // Power-on reset with the encoder at rest.
    do_reset(2'b00);

    // Glitch shorter than the debounce window, then a real up step.
    glitch(2'b10, D - 1);
    step(2'b10, 1'b1, D + 8);

    // Back to 00, then a full down detent.
    step(2'b00, 1'b1, 10);
    step(2'b01, 1'b1, 10);
    step(2'b11, 1'b1, 10);
    step(2'b10, 1'b1, 10);
    step(2'b00, 1'b1, 10);

    // Both phases at once, then frozen steps, then one live step.
    step(2'b11, 1'b1, D + 8);
    step_dir(1'b1, 1'b0, 10);
    step_dir(1'b1, 1'b0, 10);
    step_dir(1'b1, 1'b1, 10);

    // Lower boundary: walk down to 0, then one more down step.
    for (int i = 0; i < 300 && m_value != 0; i++) step_dir(1'b0, 1'b1, D + 4);
    step_dir(1'b0, 1'b1, D + 4);
    // Upper boundary: walk up to max, then one more up step.
    for (int i = 0; i < 300 && m_value != VMAX; i++) step_dir(1'b1, 1'b1, D + 4);
    step_dir(1'b1, 1'b1, D + 4);

    // Randomised mix of glitches, illegal jumps and (possibly frozen) steps.
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        r_mask = 2'($urandom_range(1, 3));
        glitch(m_pos ^ r_mask, $urandom_range(1, D - 1));
      end else if (kind == 2) begin
        step(m_pos ^ 2'b11, ($urandom_range(0, 1) == 1), $urandom_range(D + 3, D + 10));
      end else begin
        step_dir(($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
                 $urandom_range(D + 3, D + 10));
      end
    end

    // Reset mid-debounce, starting from a settled 00 position.
    for (int i = 0; i < 4 && m_pos != 2'b00; i++) step_dir(1'b1, 1'b1, D + 4);
    do_reset(2'b10);
    // Reset with the encoder resting at 11: first update is illegal.
    do_reset(2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
